// File: rtl/exec_sequencer_if.sv
// Instruction handshake, register-file bus and status outputs of exec_sequencer.
// master: the sequencer side; slave: fetch / register-file / observer side.
interface exec_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] rf_a_add;
  logic [ADDR_W-1:0] rf_b_add;
  logic [ADDR_W-1:0] rf_d_add;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_we;
  logic              flag_z;
  logic              flag_c;
  logic              flag_n;
  logic              done;
  logic              illegal_op;

  modport master (
    input  instr, instr_valid, rf_data_a, rf_data_b,
    output instr_ready, rf_a_add, rf_b_add, rf_d_add, rf_wdata, rf_we,
           flag_z, flag_c, flag_n, done, illegal_op
  );

  modport slave (
    output instr, instr_valid, rf_data_a, rf_data_b,
    input  instr_ready, rf_a_add, rf_b_add, rf_d_add, rf_wdata, rf_we,
           flag_z, flag_c, flag_n, done, illegal_op
  );
endinterface

// File: rtl/exec_sequencer.sv
// Execute/writeback sequencer for an 8x8 register file, one instruction in flight.
// Optional feature macro: EXEC_MUL_EN (opcode B = iterative shift-add multiply).
//
// state | meaning
// IDLE  | ready for a new instruction, latch it on valid
// READ  | register-file addresses presented
// EXEC  | read data sampled, result and flags registered
// MUL   | shift-add multiply, DATA_W cycles (EXEC_MUL_EN only)
// WB    | write strobe, done / illegal pulse, flags visible
module exec_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  exec_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic              we_q, ill_q;
  logic [DATA_W-1:0] wdata_q;
  logic              z_q, c_q, n_q;
  logic [ADDR_W-1:0] a_add_q, b_add_q, d_add_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_wr, alu_zn, alu_setc, alu_ill, alu_mul;
  logic [DATA_W:0]   sum, diff;

`ifdef EXEC_MUL_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [2*DATA_W-1:0] mcand, acc, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    mul_cnt;

  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.instr_valid) state_nxt = READ;
      READ: state_nxt = EXEC;
`ifdef EXEC_MUL_EN
      EXEC: state_nxt = (op_q == 4'hB) ? MUL : WB;
      MUL:  if (mul_cnt == '0) state_nxt = WB;
`else
      EXEC: state_nxt = WB;
      MUL:  state_nxt = IDLE;
`endif
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU: result plus which of write / Z,N / C this opcode updates
  always_comb begin
    sum      = {1'b0, bus.rf_data_a} + {1'b0, bus.rf_data_b};
    diff     = {1'b0, bus.rf_data_a} - {1'b0, bus.rf_data_b};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_wr   = 1'b0;
    alu_zn   = 1'b0;
    alu_setc = 1'b0;
    alu_ill  = 1'b0;
    alu_mul  = 1'b0;
    case (op_q)
      4'h0: ;
      4'h1: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h2: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h3: begin alu_res = bus.rf_data_a & bus.rf_data_b; alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h4: begin alu_res = bus.rf_data_a | bus.rf_data_b; alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h5: begin alu_res = bus.rf_data_a ^ bus.rf_data_b; alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h6: begin alu_res = {bus.rf_data_a[DATA_W-2:0], 1'b0}; alu_c = bus.rf_data_a[DATA_W-1]; alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h7: begin alu_res = {1'b0, bus.rf_data_a[DATA_W-1:1]}; alu_c = bus.rf_data_a[0]; alu_wr = 1'b1; alu_zn = 1'b1; alu_setc = 1'b1; end
      4'h8: begin alu_res = imm_q;         alu_wr = 1'b1; alu_zn = 1'b1; end
      4'h9: begin alu_res = bus.rf_data_a; alu_wr = 1'b1; alu_zn = 1'b1; end
      4'hA: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; alu_zn = 1'b1; alu_setc = 1'b1; end
`ifdef EXEC_MUL_EN
      4'hB: alu_mul = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Instruction latch, result/flag registers and multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      imm_q   <= '0;
      a_add_q <= '0;
      b_add_q <= '0;
      d_add_q <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
      wdata_q <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      mul_cnt <= '0;
`endif
    end else begin
      if (state == IDLE && bus.instr_valid) begin
        op_q    <= bus.instr[15:12];
        imm_q   <= bus.instr[DATA_W-1:0];
        d_add_q <= bus.instr[11:9];
        a_add_q <= bus.instr[8:6];
        b_add_q <= bus.instr[5:3];
      end
      if (state == EXEC) begin
        we_q  <= alu_wr | alu_mul;
        ill_q <= alu_ill;
        if (alu_wr)   wdata_q <= alu_res;
        if (alu_zn)   begin z_q <= (alu_res == '0); n_q <= alu_res[DATA_W-1]; end
        if (alu_setc) c_q <= alu_c;
`ifdef EXEC_MUL_EN
        mcand   <= {{DATA_W{1'b0}}, bus.rf_data_a};
        mplier  <= bus.rf_data_b;
        acc     <= '0;
        mul_cnt <= CNT_W'(DATA_W - 1);
`endif
      end
`ifdef EXEC_MUL_EN
      if (state == MUL) begin
        acc     <= acc_nxt;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt - 1'b1;
        if (mul_cnt == '0) begin
          wdata_q <= acc_nxt[DATA_W-1:0];
          z_q     <= (acc_nxt[DATA_W-1:0] == '0);
          n_q     <= acc_nxt[DATA_W-1];
          c_q     <= |acc_nxt[2*DATA_W-1:DATA_W];
        end
      end
`endif
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.rf_a_add    = a_add_q;
  assign bus.rf_b_add    = b_add_q;
  assign bus.rf_d_add    = d_add_q;
  assign bus.rf_wdata    = wdata_q;
  assign bus.rf_we       = (state == WB) && we_q;
  assign bus.done        = (state == WB);
  assign bus.illegal_op  = (state == WB) && ill_q;
  assign bus.flag_z      = z_q;
  assign bus.flag_c      = c_q;
  assign bus.flag_n      = n_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed testbench for exec_sequencer with a behavioural 8x8 register file.
module tb_exec_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  exec_sequencer_if bus ();

  exec_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file: synchronous read (data one cycle after address), write on rf_we
  logic [7:0] rf [8];
  logic       pl_we;
  logic [2:0] pl_a;
  logic [7:0] pl_d;
  int         we_count = 0;

  always @(posedge clk) begin
    if (pl_we) rf[pl_a] <= pl_d;
    else if (bus.rf_we) begin
      rf[bus.rf_d_add] <= bus.rf_wdata;
      we_count <= we_count + 1;
    end
    bus.rf_data_a <= rf[bus.rf_a_add];
    bus.rf_data_b <= rf[bus.rf_b_add];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Issue one instruction and check the WB-cycle outputs against expectations
  task automatic exp_run(input string tag, input logic [15:0] ins, input int exp_cyc,
                         input logic exp_we, input logic [7:0] exp_wd,
                         input logic exp_ill, input logic [2:0] exp_zcn);
    int   k;
    int   cyc;
    logic got, busy_rdy, r_we, r_ill;
    logic [7:0] r_wd;
    logic [2:0] r_zcn;
    got = 1'b0; cyc = 0; busy_rdy = 1'b1;
    r_we = 1'b0; r_ill = 1'b0; r_wd = '0; r_zcn = '0;
    @(negedge clk);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    k = 0;
    while (!bus.instr_ready && k < 50) begin @(negedge clk); k++; end
    chk({tag, "_accept"}, bus.instr_ready, 1'b1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) busy_rdy = bus.instr_ready;
      if (bus.done) begin
        got = 1'b1; cyc = i;
        r_we = bus.rf_we; r_wd = bus.rf_wdata; r_ill = bus.illegal_op;
        r_zcn = {bus.flag_z, bus.flag_c, bus.flag_n};
      end
    end
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_busy_ready"}, busy_rdy, 1'b0);
    chk({tag, "_we"}, r_we, exp_we);
    if (exp_we) chk({tag, "_wdata"}, r_wd, exp_wd);
    chk({tag, "_illegal"}, r_ill, exp_ill);
    chk({tag, "_zcn"}, r_zcn, exp_zcn);
    @(negedge clk);
    chk({tag, "_ready_after"}, bus.instr_ready, 1'b1);
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.rf_we, bus.done, bus.illegal_op, bus.flag_z, bus.flag_c, bus.flag_n,
            bus.rf_a_add, bus.rf_b_add, bus.rf_d_add, bus.rf_wdata};
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", bus.instr_ready, 1'b1);

    preload(3'd0, 8'h03);
    preload(3'd1, 8'hF0);
    preload(3'd2, 8'h20);
    preload(3'd3, 8'h55);
    preload(3'd5, 8'h05);
    preload(3'd6, 8'h05);
    preload(3'd7, 8'h04);

    // ADD r3,r1,r2 aborted by reset during EXEC
    @(negedge clk);
    bus.instr = 16'h1650;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midreset_outputs", out_vec(), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", bus.instr_ready, 1'b1);
    chk("midreset_no_write", we_count, 0);
    chk("midreset_r3", rf[3], 8'h55);

    exp_run("add", 16'h1650, 3, 1'b1, 8'h10, 1'b0, 3'b010);
    chk("add_r3", rf[3], 8'h10);
    exp_run("sub", 16'h2970, 3, 1'b1, 8'h00, 1'b0, 3'b100);
    chk("sub_r4", rf[4], 8'h00);
    exp_run("cmp", 16'hA038, 3, 1'b0, 8'h00, 1'b0, 3'b011);
    chk("cmp_r0", rf[0], 8'h03);
    exp_run("ldi", 16'h8E80, 3, 1'b1, 8'h80, 1'b0, 3'b011);
    chk("ldi_r7", rf[7], 8'h80);
    exp_run("mov", 16'h95C0, 3, 1'b1, 8'h80, 1'b0, 3'b011);
    chk("mov_r2", rf[2], 8'h80);
    exp_run("op_d", 16'hD000, 3, 1'b0, 8'h00, 1'b1, 3'b011);

    preload(3'd1, 8'h13);
    preload(3'd2, 8'h11);
`ifdef EXEC_MUL_EN
    exp_run("mul", 16'hBC50, 11, 1'b1, 8'h43, 1'b0, 3'b010);
    chk("mul_r6", rf[6], 8'h43);
`else
    exp_run("op_b", 16'hBC50, 3, 1'b0, 8'h00, 1'b1, 3'b011);
    chk("op_b_r6", rf[6], 8'h05);
`endif
    exp_run("add_alias", 16'h1248, 3, 1'b1, 8'h26, 1'b0, 3'b000);
    chk("add_alias_r1", rf[1], 8'h26);
    exp_run("shr", 16'h7680, 3, 1'b1, 8'h08, 1'b0, 3'b010);
    exp_run("shl", 16'h6A40, 3, 1'b1, 8'h4C, 1'b0, 3'b000);
    exp_run("xor", 16'h5048, 3, 1'b1, 8'h00, 1'b0, 3'b100);
    chk("xor_r0", rf[0], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
